// File: rtl/uart_rx_multi_operand.sv
// UART receiver packing NUM_OPERANDS big-endian operands; o_data/o_done update one cycle after the last stop sample.
// No backpressure: every completed packet overwrites o_data, so the consumer must take it on the o_done pulse.
module uart_rx_multi_operand #(
  parameter int SIZE_DATA     = 32,
  parameter int NUM_OPERANDS  = 2,
  parameter int OVER_SAMPLING = 16,
  parameter int SIZE_BAUD     = 24,
  parameter bit PARITY_EN     = 1'b0,
  parameter bit PARITY_ODD    = 1'b0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_rx_en,
  input  logic [SIZE_BAUD-1:0]              i_baud_div,
  input  logic                              i_rx_data,
  input  logic                              i_clear,
  output logic [NUM_OPERANDS*SIZE_DATA-1:0] o_data,
  output logic                              o_done,
  output logic                              o_busy,
  output logic                              o_frame_err,
  output logic                              o_parity_err
);

  localparam int BPO = SIZE_DATA / 8;
  localparam int NB  = NUM_OPERANDS * BPO;
  localparam int W   = NUM_OPERANDS * SIZE_DATA;
  localparam int JW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW  = $clog2(OVER_SAMPLING);
  localparam int OW  = $clog2(W);
  localparam logic [SW-1:0] S_HALF = SW'(OVER_SAMPLING / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVER_SAMPLING - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NB - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [SIZE_BAUD-1:0] r_baud_cnt, r_baud_div;
  logic [1:0]           r_sync;
  logic [SW-1:0]        r_s, w_s_nxt;
  logic [2:0]           r_bit, w_bit_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic                 r_par_bad, w_par_bad_nxt;
  logic [JW-1:0]        r_j;
  logic [W-1:0]         r_shadow, w_shadow_upd, r_data;
  logic                 r_done, r_frame_err, r_parity_err;
  logic                 w_tick, w_line, w_byte_ok, w_byte_err, w_ferr_set, w_perr_set;
  logic [31:0]          w_j32;
  logic [OW-1:0]        w_off;

  assign w_tick = (r_baud_cnt == r_baud_div);
  assign w_line = r_sync[1];

  // Divisor is latched at the wrap so a mid-period change cannot skip the compare.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_baud_cnt <= '0;
      r_baud_div <= '0;
    end else if (w_tick) begin
      r_baud_cnt <= '0;
      r_baud_div <= i_baud_div;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_s_nxt       = r_s;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_par_bad_nxt = r_par_bad;
    w_byte_ok     = 1'b0;
    w_byte_err    = 1'b0;
    w_ferr_set    = 1'b0;
    w_perr_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_en && !w_line) begin
          w_state_nxt = ST_START;
          w_s_nxt     = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_s == S_HALF) begin
            w_state_nxt = w_line ? ST_IDLE : ST_DATA;
            w_s_nxt     = '0;
            w_bit_nxt   = '0;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_shift_nxt = {w_line, r_shift[7:1]};
            w_s_nxt     = '0;
            if (r_bit == 3'd7) begin
              w_state_nxt   = PARITY_EN ? ST_PARITY : ST_STOP;
              w_par_bad_nxt = 1'b0;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_par_bad_nxt = (w_line != ((^r_shift) ^ PARITY_ODD));
            w_s_nxt       = '0;
            w_state_nxt   = ST_STOP;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_s_nxt     = '0;
            w_state_nxt = ST_IDLE;
            w_ferr_set  = !w_line;
            w_perr_set  = r_par_bad;
            w_byte_ok   = w_line && !r_par_bad;
            w_byte_err  = !w_line || r_par_bad;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte j lands in operand j/BPO, first byte of an operand in its MSB.
  always_comb begin
    w_j32        = 32'(r_j);
    w_off        = OW'((w_j32 / BPO) * SIZE_DATA + (BPO - 1 - (w_j32 % BPO)) * 8);
    w_shadow_upd = r_shadow;
    w_shadow_upd[w_off +: 8] = r_shift;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_sync       <= 2'b11;
      r_s          <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_j          <= '0;
      r_shadow     <= '0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_rx_data};
      r_state   <= w_state_nxt;
      r_s       <= w_s_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bad <= w_par_bad_nxt;
      r_done    <= 1'b0;
      if (w_byte_ok) begin
        r_shadow <= w_shadow_upd;
        if (r_j == J_LAST) begin
          r_data <= w_shadow_upd;
          r_done <= 1'b1;
          r_j    <= '0;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end else if (w_byte_err) begin
        r_j <= '0;
      end
      if (w_ferr_set)   r_frame_err  <= 1'b1;
      else if (i_clear) r_frame_err  <= 1'b0;
      if (w_perr_set)   r_parity_err <= 1'b1;
      else if (i_clear) r_parity_err <= 1'b0;
    end
  end

  assign o_data       = r_data;
  assign o_done       = r_done;
  assign o_busy       = (r_state != ST_IDLE) || (r_j != '0);
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx_multi_operand.sv
// Bench for uart_rx_multi_operand: default instance plus an even-parity instance, scoreboarded packets.
module tb_uart_rx_multi_operand;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en = 1'b1;
  logic        clear = 1'b0;
  logic [23:0] baud_div = '0;
  logic        rx_a = 1'b1;
  logic        rx_p = 1'b1;
  logic [63:0] data_a, data_p;
  logic        done_a, busy_a, ferr_a, perr_a;
  logic        done_p, busy_p, ferr_p, perr_p;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_done_a = 0;
  int          n_done_p = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_p[$];
  logic [63:0] last_a = '0;
  logic [63:0] exp_a, exp_p;
  logic        prev_done_a = 1'b0;
  logic        prev_done_p = 1'b0;

  always #5 clk = ~clk;

  uart_rx_multi_operand dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx_en(rx_en), .i_baud_div(baud_div), .i_rx_data(rx_a),
    .i_clear(clear), .o_data(data_a), .o_done(done_a), .o_busy(busy_a),
    .o_frame_err(ferr_a), .o_parity_err(perr_a)
  );

  uart_rx_multi_operand #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_rx_en(rx_en), .i_baud_div(baud_div), .i_rx_data(rx_p),
    .i_clear(clear), .o_data(data_p), .o_done(done_p), .o_busy(busy_p),
    .o_frame_err(ferr_p), .o_parity_err(perr_p)
  );

  // Packet model: bytes listed first-sent at [63:56]; each operand shifts bytes in MSB-first.
  function automatic logic [63:0] pack(input logic [63:0] bytes_in);
    logic [31:0] op0, op1;
    op0 = '0;
    op1 = '0;
    for (int j = 0; j < 4; j++) op0 = {op0[23:0], bytes_in[63-8*j -: 8]};
    for (int j = 4; j < 8; j++) op1 = {op1[23:0], bytes_in[63-8*j -: 8]};
    return {op1, op0};
  endfunction

  function automatic int bit_cycles();
    return 16 * (int'(baud_div) + 1);
  endfunction

  always @(negedge clk) begin
    if (done_a) begin
      n_done_a++;
      n_tests++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL done_a_unexpected: got o_data=%h, expected no packet", data_a);
      end else begin
        exp_a = q_a.pop_front();
        if (data_a !== exp_a) begin
          n_fail++;
          $display("FAIL data_a: got %h, expected %h", data_a, exp_a);
        end
      end
      n_tests++;
      if (prev_done_a) begin
        n_fail++;
        $display("FAIL done_a_width: got 2+ cycle pulse, expected 1 cycle");
      end
    end
    if (done_p) begin
      n_done_p++;
      n_tests++;
      if (q_p.size() == 0) begin
        n_fail++;
        $display("FAIL done_p_unexpected: got o_data=%h, expected no packet", data_p);
      end else begin
        exp_p = q_p.pop_front();
        if (data_p !== exp_p) begin
          n_fail++;
          $display("FAIL data_p: got %h, expected %h", data_p, exp_p);
        end
      end
    end
    prev_done_a = done_a;
    prev_done_p = done_p;
  end

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx_p = v;
    else     rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input bit sel, input int nbits);
    drive(sel, 1'b1, nbits * bit_cycles());
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop,
                           input logic par_bit, input bit par_en);
    int bc;
    bc = bit_cycles();
    drive(sel, 1'b0, bc);
    for (int i = 0; i < 8; i++) drive(sel, b[i], bc);
    if (par_en) drive(sel, par_bit, bc);
    drive(sel, stop, bc);
    if (sel) rx_p = 1'b1;
    else     rx_a = 1'b1;
  endtask

  task automatic send_packet(input bit sel, input logic [63:0] bytes_in);
    logic [7:0] b;
    if (sel) q_p.push_back(pack(bytes_in));
    else begin
      q_a.push_back(pack(bytes_in));
      last_a = pack(bytes_in);
    end
    for (int j = 0; j < 8; j++) begin
      b = bytes_in[63-8*j -: 8];
      send_byte(sel, b, 1'b1, ^b, sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (data_a !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", data_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done_a); end
    n_tests++; if ({ferr_a, perr_a, ferr_p, perr_p} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {ferr_a, perr_a, ferr_p, perr_p}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({busy_a, busy_p} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b, expected 00", {busy_a, busy_p}); end
  endtask

  task automatic test_valid_packet();
    int n0;
    n0 = n_done_a;
    send_packet(1'b0, 64'h3F800000_40000000);
    idle(1'b0, 2);
    n_tests++; if (n_done_a !== n0 + 1) begin n_fail++; $display("FAIL valid_done_count: got %0d, expected %0d", n_done_a - n0, 1); end
    n_tests++; if (data_a[31:0] !== 32'h3F800000) begin n_fail++; $display("FAIL valid_op0: got %h, expected 3f800000", data_a[31:0]); end
    n_tests++; if (data_a[63:32] !== 32'h40000000) begin n_fail++; $display("FAIL valid_op1: got %h, expected 40000000", data_a[63:32]); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL valid_busy: got %b, expected 0", busy_a); end
  endtask

  task automatic test_start_glitch();
    int n0;
    n0 = n_done_a;
    drive(1'b0, 1'b0, 4 * (int'(baud_div) + 1));
    idle(1'b0, 2);
    n_tests++; if ({busy_a, ferr_a, perr_a} !== 3'b000) begin n_fail++; $display("FAIL glitch_state: got busy/ferr/perr=%b, expected 000", {busy_a, ferr_a, perr_a}); end
    n_tests++; if (n_done_a !== n0) begin n_fail++; $display("FAIL glitch_no_done: got %0d pulses, expected 0", n_done_a - n0); end
    send_packet(1'b0, 64'h11223344_55667788);
    idle(1'b0, 2);
    n_tests++; if (q_a.size() != 0 || n_done_a !== n0 + 1) begin n_fail++; $display("FAIL glitch_followup: got %0d pulses, expected 1", n_done_a - n0); end
  endtask

  task automatic test_frame_error();
    int n0;
    n0 = n_done_a;
    send_byte(1'b0, 8'hA1, 1'b1, 1'b0, 1'b0);
    send_byte(1'b0, 8'hB2, 1'b1, 1'b0, 1'b0);
    send_byte(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0);
    send_byte(1'b0, 8'hD4, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 2);
    n_tests++; if (ferr_a !== 1'b1) begin n_fail++; $display("FAIL frame_flag: got %b, expected 1", ferr_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL frame_abort: got busy=%b, expected 0", busy_a); end
    n_tests++; if (n_done_a !== n0 || data_a !== last_a) begin n_fail++; $display("FAIL frame_data_kept: got %h, expected %h", data_a, last_a); end
    send_packet(1'b0, 64'hC0490FDB_3FC00000);
    idle(1'b0, 2);
    n_tests++; if (q_a.size() != 0 || n_done_a !== n0 + 1) begin n_fail++; $display("FAIL frame_recover: got %0d pulses, expected 1", n_done_a - n0); end
    n_tests++; if (ferr_a !== 1'b1) begin n_fail++; $display("FAIL frame_sticky: got %b, expected 1", ferr_a); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    n_tests++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL frame_clear: got %b, expected 0", ferr_a); end
  endtask

  task automatic test_parity();
    int n0;
    n0 = n_done_p;
    send_byte(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);
    n_tests++; if ({perr_p, ferr_p, busy_p} !== 3'b100) begin n_fail++; $display("FAIL parity_bad: got perr/ferr/busy=%b, expected 100", {perr_p, ferr_p, busy_p}); end
    send_byte(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 1);
    n_tests++; if ({perr_p, busy_p} !== 2'b11) begin n_fail++; $display("FAIL parity_good: got perr/busy=%b, expected 11", {perr_p, busy_p}); end
    q_p.push_back(pack(64'h01020304_05060708));
    for (int j = 2; j <= 8; j++) send_byte(1'b1, 8'(j), 1'b1, ^(8'(j)), 1'b1);
    idle(1'b1, 2);
    n_tests++; if (q_p.size() != 0 || n_done_p !== n0 + 1) begin n_fail++; $display("FAIL parity_packet: got %0d pulses, expected 1", n_done_p - n0); end
  endtask

  task automatic test_reset_mid_packet();
    logic [63:0] junk;
    int n0;
    junk = 64'hDEADBEEF_01020304;
    for (int j = 0; j < 5; j++) send_byte(1'b0, junk[63-8*j -: 8], 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (data_a !== 64'h0 || done_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data: got %h, expected 0", data_a); end
    n_tests++; if ({busy_a, ferr_a, perr_a, perr_p} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_state: got %b, expected 0000", {busy_a, ferr_a, perr_a, perr_p}); end
    n0 = n_done_a;
    send_packet(1'b0, 64'h40490FDB_BF800000);
    idle(1'b0, 2);
    n_tests++; if (q_a.size() != 0 || n_done_a !== n0 + 1) begin n_fail++; $display("FAIL rst_mid_packet: got %0d pulses, expected 1", n_done_a - n0); end
  endtask

  task automatic test_clear_collision_and_div();
    int n0;
    clear = 1'b1;
    fork
      send_byte(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
      begin
        // Release clear right after the flag appears so only the set cycle overlaps.
        for (int i = 0; i < 400 && !ferr_a; i++) @(negedge clk);
        clear = 1'b0;
      end
    join
    idle(1'b0, 2);
    n_tests++; if (ferr_a !== 1'b1) begin n_fail++; $display("FAIL clear_collision: got %b, expected 1", ferr_a); end
    baud_div = 24'd3;
    idle(1'b0, 2);
    n0 = n_done_a;
    send_packet(1'b0, 64'h41200000_C1200000);
    idle(1'b0, 2);
    n_tests++; if (q_a.size() != 0 || n_done_a !== n0 + 1) begin n_fail++; $display("FAIL div3_packet: got %0d pulses, expected 1", n_done_a - n0); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL div3_busy: got %b, expected 0", busy_a); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_packet();
    test_start_glitch();
    test_frame_error();
    test_parity();
    test_reset_mid_packet();
    test_clear_collision_and_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
